// File: rtl/mult_hilo_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply control stage.
// Also holds the sign-magnitude helper used on operand capture.
package mult_hilo_ctrl_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    // |v| when v is a negative two's-complement value and signed mode is on.
    // |-32768| = 0x8000 still fits in the unsigned 16-bit magnitude.
    function automatic logic [OP_W-1:0] mag_of(input logic [OP_W-1:0] v,
                                               input logic            sgn);
        return (sgn && v[OP_W-1]) ? (~v + OP_W'(1)) : v;
    endfunction

endpackage

// File: rtl/mult_hilo_ctrl_mult.sv
// Combinational 16x16 unsigned array multiplier.
// The result ripples through shifted partial-product rows.
module mult
    import mult_hilo_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    output logic [PROD_W-1:0] result
);

    logic [PROD_W-1:0] w_acc;
    logic [PROD_W-1:0] w_a_ext;

    assign w_a_ext = {{(PROD_W-OP_W){1'b0}}, A};

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (B[i]) w_acc = w_acc + (w_a_ext << i);
        end
    end

    assign result = w_acc;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Multiply control: captures operands, waits for the array to settle,
// then writes the (sign-corrected) product into HI/LO.
module mult_hilo_ctrl
    import mult_hilo_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic [OP_W-1:0] op_a,
    input  logic [OP_W-1:0] op_b,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [OP_W-1:0] wr_data,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [OP_W-1:0] hi,
    output logic [OP_W-1:0] lo
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [OP_W-1:0]    r_mag_a;
    logic [OP_W-1:0]    r_mag_b;
    logic               r_neg;
    logic               r_done;
    logic [OP_W-1:0]    r_hi;
    logic [OP_W-1:0]    r_lo;
    logic               w_accept;
    logic               w_capture;
    logic [PROD_W-1:0]  w_prod;
    logic [PROD_W-1:0]  w_result;

    mult u_mult (
        .A      (r_mag_a),
        .B      (r_mag_b),
        .result (w_prod)
    );

    assign w_result = r_neg ? (~w_prod + PROD_W'(1)) : w_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= w_capture;
            if (w_accept) begin
                r_mag_a <= mag_of(op_a, is_signed);
                r_mag_b <= mag_of(op_b, is_signed);
                r_neg   <= is_signed & (op_a[OP_W-1] ^ op_b[OP_W-1]);
                r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            end else if (r_state == ST_SETTLE && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // MTHI/MTLO only land in IDLE; a capture later overwrites them.
            if (w_capture) begin
                {r_hi, r_lo} <= w_result;
            end else if (r_state == ST_IDLE) begin
                if (wr_hi) r_hi <= wr_data;
                if (wr_lo) r_lo <= wr_data;
            end
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign busy  = ~ready;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl: latency, signed/unsigned products,
// busy-time rules, MTHI/MTLO writes and asynchronous reset abort.
module tb_mult_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [15:0] wr_data = '0;
    logic        ready, busy, done;
    logic [15:0] hi, lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_hilo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wr_data   (wr_data),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Presents start for one cycle, then counts edges
    // (the accepting edge is edge 1) until done is seen. Returns at the
    // negedge of the done cycle; lat=0 means done never came.
    task automatic mul(input logic [15:0] a, input logic [15:0] b,
                       input logic s, output int lat);
        start = 1'b1; op_a = a; op_b = b; is_signed = s;
        @(negedge clk);
        start = 1'b0; op_a = 16'h5A5A; op_b = 16'hA5A5; is_signed = ~s;
        lat = 0;
        if (ready !== 1'b0) chk("ready_low_after_accept", {31'b0, ready}, 32'd0);
        for (int n = 2; n < 30; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat;

    initial begin
        #12;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_busy",  {31'b0, busy},  32'd0);
        chk("rst_done",  {31'b0, done},  32'd0);
        chk("rst_hilo",  {hi, lo},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // unsigned small
        mul(16'd3, 16'd5, 1'b0, lat);
        chk("u3x5_lat",  lat, 32'd5);
        chk("u3x5_hilo", {hi, lo}, 32'h0000_000F);
        chk("u3x5_ready_in_done", {31'b0, ready}, 32'd1);
        @(negedge clk);
        chk("u3x5_done_pulse", {31'b0, done}, 32'd0);

        mul(16'hFFFF, 16'hFFFF, 1'b0, lat);
        chk("umax_hilo", {hi, lo}, 32'hFFFE_0001);
        mul(16'hFFFE, 16'd3, 1'b1, lat);
        chk("s_m2x3", {hi, lo}, 32'hFFFF_FFFA);
        mul(16'hFFFF, 16'hFFFF, 1'b1, lat);
        chk("s_m1xm1", {hi, lo}, 32'h0000_0001);
        mul(16'h8000, 16'h8000, 1'b1, lat);
        chk("s_minxmin", {hi, lo}, 32'h4000_0000);
        @(negedge clk);

        // busy rules: start 2x3, then stray start 7x7 and MTHI during SETTLE
        start = 1'b1; op_a = 16'd2; op_b = 16'd3; is_signed = 1'b0;
        @(negedge clk);
        op_a = 16'd7; op_b = 16'd7; wr_hi = 1'b1; wr_data = 16'h1234;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        chk("busy_wrhi_ignored", {16'b0, hi}, 32'h0000_4000);
        lat = 0;
        for (int n = 3; n < 30; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin lat = n; break; end
        end
        chk("busy_lat",  lat, 32'd5);
        chk("busy_hilo", {hi, lo}, 32'h0000_0006);
        begin
            int extra = 0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            chk("busy_no_second_done", extra, 32'd0);
        end

        // back-to-back start in the done cycle
        mul(16'd4, 16'd5, 1'b0, lat);
        chk("b2b_first", {hi, lo}, 32'd20);
        mul(16'd6, 16'd7, 1'b0, lat);
        chk("b2b_lat",    lat, 32'd5);
        chk("b2b_second", {hi, lo}, 32'd42);
        @(negedge clk);

        // MTHI/MTLO in IDLE, then overwritten by a multiply
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 16'hBEEF;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mt_hilo", {hi, lo}, 32'hBEEF_BEEF);
        mul(16'd2, 16'd2, 1'b0, lat);
        chk("mt_overwrite", {hi, lo}, 32'h0000_0004);
        @(negedge clk);

        // asynchronous reset two cycles into SETTLE
        start = 1'b1; op_a = 16'h1234; op_b = 16'h5678; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_hilo",  {hi, lo}, 32'd0);
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_busy",  {31'b0, busy},  32'd0);
        chk("abort_done",  {31'b0, done},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (done === 1'b1) seen++;
            end
            chk("abort_no_done", seen, 32'd0);
            chk("abort_hilo_after", {hi, lo}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout got=running exp=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
